// File: rtl/osd_scm_multi.sv
// osd_scm_multi: system control module for the debug subnet.
// Serves the identification registers and drives NUM_RST reset domains, each of
// which can be held (sticky) or pulsed for PULSE_LEN cycles with staggered release.
// Optional watchdog that auto-pulses every domain: define OSD_SCM_WATCHDOG_EN.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no pulse in flight
// ST_ASSERT  | pulsed domains held, cnt counting down PULSE_LEN
// ST_RELEASE | lowest pulsed domain dropped every RELEASE_GAP cycles

module osd_scm_multi #(
    parameter int unsigned SYSTEM_VENDOR_ID  = 0,
    parameter int unsigned SYSTEM_DEVICE_ID  = 0,
    parameter int unsigned NUM_MOD           = 1,
    parameter int unsigned MAX_PKT_LEN       = 12,
    parameter int unsigned NUM_RST           = 2,
    parameter int unsigned PULSE_LEN_DEFAULT = 16,
    parameter int unsigned RELEASE_GAP       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               reg_request,
    input  logic               reg_write,
    input  logic [15:0]        reg_addr,
    input  logic [1:0]         reg_size,
    input  logic [15:0]        reg_wdata,
    output logic               reg_ack,
    output logic               reg_err,
    output logic [15:0]        reg_rdata,
    output logic [NUM_RST-1:0] rst_out,
    output logic               rst_busy
);

    localparam logic [15:0] ADDR_VENDOR     = 16'h0200;
    localparam logic [15:0] ADDR_DEVICE     = 16'h0201;
    localparam logic [15:0] ADDR_NUM_MOD    = 16'h0202;
    localparam logic [15:0] ADDR_MAX_PKT    = 16'h0203;
    localparam logic [15:0] ADDR_RST_CTRL   = 16'h0204;
    localparam logic [15:0] ADDR_RST_PULSE  = 16'h0205;
    localparam logic [15:0] ADDR_PULSE_LEN  = 16'h0206;
    localparam logic [15:0] ADDR_RST_STATUS = 16'h0207;
    localparam logic [15:0] ADDR_NUM_RST    = 16'h0208;
`ifdef OSD_SCM_WATCHDOG_EN
    localparam logic [15:0] ADDR_WDT_LOAD   = 16'h0209;
    localparam logic [15:0] ADDR_WDT_KICK   = 16'h020A;
    localparam logic [15:0] ADDR_WDT_STAT   = 16'h020B;
`endif

    localparam logic [15:0] VENDOR16    = 16'(SYSTEM_VENDOR_ID);
    localparam logic [15:0] DEVICE16    = 16'(SYSTEM_DEVICE_ID);
    localparam logic [15:0] NUM_MOD16   = 16'(NUM_MOD);
    localparam logic [15:0] MAX_PKT16   = 16'(MAX_PKT_LEN);
    localparam logic [15:0] NUM_RST16   = 16'(NUM_RST);
    localparam logic [15:0] PLEN_RESET  = 16'(PULSE_LEN_DEFAULT);
    localparam logic [7:0]  GAP_LOAD    = 8'(RELEASE_GAP);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_RST-1:0] sticky_q, sticky_d;
    logic [NUM_RST-1:0] pulse_q, pulse_d;
    logic [NUM_RST-1:0] rst_out_q, rst_out_d;
    logic               busy_q, busy_d;
    logic [15:0]        plen_q, plen_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [7:0]         gap_q, gap_d;

    logic               addr_known, addr_ro, addr_wo;
    logic [15:0]        rdata;
    logic               wr_ok;
    logic [NUM_RST-1:0] wdata_n;
    logic [NUM_RST-1:0] trig;
    logic               wdt_fire;

`ifdef OSD_SCM_WATCHDOG_EN
    logic [15:0]        wdt_load_q, wdt_load_d;
    logic [15:0]        wdt_cnt_q, wdt_cnt_d;
    logic               wdt_stat_q, wdt_stat_d;
`endif

    assign wdata_n   = reg_wdata[NUM_RST-1:0];
    assign reg_ack   = reg_request;
    assign reg_rdata = rdata;
    assign rst_out   = rst_out_q;
    assign rst_busy  = busy_q;

    // Address decode, access checking and read mux.
    always_comb begin
        addr_known = 1'b1;
        addr_ro    = 1'b0;
        addr_wo    = 1'b0;
        rdata      = '0;
        case (reg_addr)
            ADDR_VENDOR:     begin addr_ro = 1'b1; rdata = VENDOR16;  end
            ADDR_DEVICE:     begin addr_ro = 1'b1; rdata = DEVICE16;  end
            ADDR_NUM_MOD:    begin addr_ro = 1'b1; rdata = NUM_MOD16; end
            ADDR_MAX_PKT:    begin addr_ro = 1'b1; rdata = MAX_PKT16; end
            ADDR_RST_CTRL:   rdata[NUM_RST-1:0] = sticky_q;
            ADDR_RST_PULSE:  rdata[NUM_RST-1:0] = pulse_q;
            ADDR_PULSE_LEN:  rdata = plen_q;
            ADDR_RST_STATUS: begin addr_ro = 1'b1; rdata[NUM_RST-1:0] = rst_out_q; end
            ADDR_NUM_RST:    begin addr_ro = 1'b1; rdata = NUM_RST16; end
`ifdef OSD_SCM_WATCHDOG_EN
            ADDR_WDT_LOAD:   rdata = wdt_load_q;
            ADDR_WDT_KICK:   addr_wo = 1'b1;
            ADDR_WDT_STAT:   rdata[0] = wdt_stat_q;
`endif
            default:         addr_known = 1'b0;
        endcase
        reg_err = reg_request & (~addr_known
                                 | (reg_size != 2'b00)
                                 | (reg_write & addr_ro)
                                 | (~reg_write & addr_wo)
                                 | (reg_write & (reg_addr == ADDR_PULSE_LEN) & (reg_wdata == 16'h0000)));
        wr_ok = reg_request & reg_write & ~reg_err;
    end

`ifdef OSD_SCM_WATCHDOG_EN
    // Watchdog: a write to WDT_LOAD or a kick beats a timeout in the same cycle.
    always_comb begin
        wdt_load_d = wdt_load_q;
        wdt_cnt_d  = wdt_cnt_q;
        wdt_stat_d = wdt_stat_q;
        wdt_fire   = 1'b0;
        if (wr_ok && reg_addr == ADDR_WDT_LOAD) begin
            wdt_load_d = reg_wdata;
            wdt_cnt_d  = reg_wdata;
        end else if (wr_ok && reg_addr == ADDR_WDT_KICK) begin
            wdt_cnt_d = wdt_load_q;
        end else if (wdt_load_q != 16'h0000) begin
            if (wdt_cnt_q <= 16'd1) begin
                wdt_fire  = 1'b1;
                wdt_cnt_d = wdt_load_q;
            end else begin
                wdt_cnt_d = wdt_cnt_q - 16'd1;
            end
        end
        if (wr_ok && reg_addr == ADDR_WDT_STAT && reg_wdata[0]) wdt_stat_d = 1'b0;
        if (wdt_fire) wdt_stat_d = 1'b1;
    end

    // Watchdog registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdt_load_q <= '0;
            wdt_cnt_q  <= '0;
            wdt_stat_q <= 1'b0;
        end else begin
            wdt_load_q <= wdt_load_d;
            wdt_cnt_q  <= wdt_cnt_d;
            wdt_stat_q <= wdt_stat_d;
        end
    end
`else
    assign wdt_fire = 1'b0;
`endif

    // Pulse sequencer next state; a new trigger always restarts the assert phase.
    always_comb begin
        state_d = state_q;
        pulse_d = pulse_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        trig    = '0;
        if (wr_ok && reg_addr == ADDR_RST_PULSE) trig = wdata_n;
        if (wdt_fire) trig = '1;
        if (trig != '0) begin
            pulse_d = pulse_q | trig;
            cnt_d   = plen_q;
            state_d = ST_ASSERT;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (cnt_q <= 16'd1) begin
                        pulse_d = pulse_q & (pulse_q - 1'b1);
                        gap_d   = GAP_LOAD;
                        state_d = (pulse_d == '0) ? ST_IDLE : ST_RELEASE;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                ST_RELEASE: begin
                    if (gap_q <= 8'd1) begin
                        pulse_d = pulse_q & (pulse_q - 1'b1);
                        gap_d   = GAP_LOAD;
                        if (pulse_d == '0) state_d = ST_IDLE;
                    end else begin
                        gap_d = gap_q - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Config registers and output stage; busy is delayed to line up with rst_out.
    always_comb begin
        sticky_d  = (wr_ok && reg_addr == ADDR_RST_CTRL) ? wdata_n : sticky_q;
        plen_d    = (wr_ok && reg_addr == ADDR_PULSE_LEN) ? reg_wdata : plen_q;
        rst_out_d = sticky_q | pulse_q;
        busy_d    = (state_q != ST_IDLE);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sticky_q  <= '0;
            pulse_q   <= '0;
            rst_out_q <= '1;
            busy_q    <= 1'b0;
            plen_q    <= PLEN_RESET;
            cnt_q     <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            sticky_q  <= sticky_d;
            pulse_q   <= pulse_d;
            rst_out_q <= rst_out_d;
            busy_q    <= busy_d;
            plen_q    <= plen_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
        end
    end

endmodule

// File: tb/tb_osd_scm_multi.sv
// Bench for osd_scm_multi: directed scenarios plus random register traffic
// against a timestamp-based reference model of the reset sequencer.

module tb_osd_scm_multi;

    localparam int unsigned VID = 32'hABCD_1234;
    localparam int unsigned DID = 32'h0000_5678;
    localparam int unsigned NM  = 3;
    localparam int unsigned MPL = 12;
    localparam int          NR  = 4;
    localparam int          PLD = 3;
    localparam int          RG  = 2;
    localparam logic [NR-1:0] MASK = '1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          reg_request, reg_write;
    logic [15:0]   reg_addr, reg_wdata, reg_rdata;
    logic [1:0]    reg_size;
    logic          reg_ack, reg_err;
    logic [NR-1:0] rst_out;
    logic          rst_busy;

    int n_tests = 0;
    int n_fail  = 0;

    osd_scm_multi #(
        .SYSTEM_VENDOR_ID(VID), .SYSTEM_DEVICE_ID(DID), .NUM_MOD(NM),
        .MAX_PKT_LEN(MPL), .NUM_RST(NR), .PULSE_LEN_DEFAULT(PLD), .RELEASE_GAP(RG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .reg_request(reg_request), .reg_write(reg_write),
        .reg_addr(reg_addr), .reg_size(reg_size), .reg_wdata(reg_wdata),
        .reg_ack(reg_ack), .reg_err(reg_err), .reg_rdata(reg_rdata),
        .rst_out(rst_out), .rst_busy(rst_busy)
    );

    always #5 clk = ~clk;

    // Reference model: register contents plus the edge at which release begins.
    logic [NR-1:0] m_sticky, m_pulse, m_out;
    logic          m_busy;
    logic [15:0]   m_plen;
    int            m_rs;
    int            edge_no = 0;
    logic [15:0]   m_wload;
    int            m_wdl;
    logic          m_wstat;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_no);
        end
    endtask

    function automatic logic exp_err(logic wr, logic [15:0] a, logic [1:0] sz, logic [15:0] wd);
        logic known, ro, wo;
        known = (a >= 16'h0200) && (a <= 16'h0208);
        ro    = known && ((a <= 16'h0203) || (a == 16'h0207) || (a == 16'h0208));
        wo    = 1'b0;
`ifdef OSD_SCM_WATCHDOG_EN
        if (a >= 16'h0209 && a <= 16'h020B) known = 1'b1;
        if (a == 16'h020A) wo = 1'b1;
`endif
        return !known || (sz != 2'b00) || (wr && ro) || (!wr && wo)
               || (wr && a == 16'h0206 && wd == 16'h0000);
    endfunction

    function automatic logic [15:0] exp_rdata(logic [15:0] a);
        case (a)
            16'h0200: return VID[15:0];
            16'h0201: return DID[15:0];
            16'h0202: return 16'(NM);
            16'h0203: return 16'(MPL);
            16'h0204: return {12'h000, m_sticky};
            16'h0205: return {12'h000, m_pulse};
            16'h0206: return m_plen;
            16'h0207: return {12'h000, m_out};
            16'h0208: return 16'(NR);
            16'h0209: return m_wload;
            16'h020B: return {15'h0000, m_wstat};
            default:  return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        m_sticky = '0; m_pulse = '0; m_out = '1; m_busy = 1'b0;
        m_plen = 16'(PLD); m_rs = 0;
        m_wload = '0; m_wdl = 0; m_wstat = 1'b0;
    endtask

    // Advance the model across one rising edge.
    task automatic model_edge(input logic rstn, input logic ok, input logic wr,
                              input logic [15:0] a, input logic [15:0] wd);
        logic [NR-1:0] new_out, trig;
        logic          new_busy, fire;
        if (!rstn) begin
            model_reset();
            return;
        end
        new_out  = m_sticky | m_pulse;
        new_busy = (m_pulse != '0);
        trig = '0;
        fire = 1'b0;
        if (ok && wr && a == 16'h0205) trig = wd[NR-1:0] & MASK;
`ifdef OSD_SCM_WATCHDOG_EN
        if (ok && wr && a == 16'h0209) begin
            m_wload = wd; m_wdl = edge_no + int'(wd);
        end else if (ok && wr && a == 16'h020A) begin
            m_wdl = edge_no + int'(m_wload);
        end else if (m_wload != 0 && edge_no == m_wdl) begin
            fire = 1'b1; m_wdl = edge_no + int'(m_wload);
        end
        if (ok && wr && a == 16'h020B && wd[0]) m_wstat = 1'b0;
        if (fire) begin m_wstat = 1'b1; trig = MASK; end
`endif
        if (trig != '0) begin
            m_pulse = m_pulse | trig;
            m_rs    = edge_no + int'(m_plen);
        end else if (m_pulse != '0 && edge_no >= m_rs && ((edge_no - m_rs) % RG) == 0) begin
            for (int i = 0; i < NR; i++) begin
                if (m_pulse[i]) begin
                    m_pulse[i] = 1'b0;
                    break;
                end
            end
        end
        if (ok && wr && a == 16'h0204) m_sticky = wd[NR-1:0];
        if (ok && wr && a == 16'h0206) m_plen = wd;
        m_out  = new_out;
        m_busy = new_busy;
    endtask

    // One clock: drive, check handshake mid-cycle, step the model, check outputs.
    task automatic do_cycle(input logic rstn, input logic req, input logic wr,
                            input logic [15:0] a, input logic [1:0] sz, input logic [15:0] wd);
        logic e_err;
        rst_n = rstn; reg_request = req; reg_write = wr;
        reg_addr = a; reg_size = sz; reg_wdata = wd;
        #3;
        e_err = req && exp_err(wr, a, sz, wd);
        check_val("ack", {31'b0, reg_ack}, {31'b0, req});
        check_val("err", {31'b0, reg_err}, {31'b0, e_err});
        if (req && !wr && !e_err) check_val("rdata", {16'b0, reg_rdata}, {16'b0, exp_rdata(a)});
        @(posedge clk);
        #1;
        model_edge(rstn, req && !e_err, wr, a, wd);
        edge_no++;
        check_val("rst_out", {28'b0, rst_out}, {28'b0, m_out});
        check_val("rst_busy", {31'b0, rst_busy}, {31'b0, m_busy});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b1, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000);
    endtask

    task automatic wr_reg(input logic [15:0] a, input logic [15:0] wd);
        do_cycle(1'b1, 1'b1, 1'b1, a, 2'b00, wd);
    endtask

    task automatic rd_reg(input logic [15:0] a);
        do_cycle(1'b1, 1'b1, 1'b0, a, 2'b00, 16'h0000);
    endtask

    logic [3:0] seq_out  [6] = '{4'h5, 4'h5, 4'h5, 4'h4, 4'h4, 4'h0};
    logic       seq_busy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        int op;
        logic [15:0] a;
        model_reset();
        rst_n = 1'b0; reg_request = 1'b0; reg_write = 1'b0;
        reg_addr = '0; reg_size = '0; reg_wdata = '0;
        @(posedge clk);
        #1;
        edge_no++;
        check_val("reset_rst_out", {28'b0, rst_out}, 32'hF);
        check_val("reset_busy", {31'b0, rst_busy}, 32'h0);
        do_cycle(1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000);

        // Identification and map after reset.
        idle(1);
        check_val("status_zero", {28'b0, rst_out}, 32'h0);
        for (int i = 0; i <= 8; i++) rd_reg(16'h0200 + 16'(i));
        rd_reg(16'h020C);
        rd_reg(16'h0209);
        rd_reg(16'h01FF);
        do_cycle(1'b1, 1'b1, 1'b0, 16'h0200, 2'b01, 16'h0000);
        wr_reg(16'h0206, 16'h0000);
        wr_reg(16'h0207, 16'h000F);
        wr_reg(16'h0200, 16'h000F);
        rd_reg(16'h0206);

        // Sticky vector with one cycle latency.
        wr_reg(16'h0204, 16'h000A);
        check_val("sticky_latency", {28'b0, rst_out}, 32'h0);
        idle(1);
        check_val("sticky_set", {28'b0, rst_out}, 32'hA);
        wr_reg(16'h0204, 16'h0000);
        idle(1);
        check_val("sticky_clr", {28'b0, rst_out}, 32'h0);

        // Pulse 0x5 with PULSE_LEN 3, gap 2.
        wr_reg(16'h0205, 16'h0005);
        for (int i = 0; i < 6; i++) begin
            idle(1);
            check_val("pulse_seq_out", {28'b0, rst_out}, {28'b0, seq_out[i]});
            check_val("pulse_seq_busy", {31'b0, rst_busy}, {31'b0, seq_busy[i]});
        end

        // Retrigger during release.
        wr_reg(16'h0205, 16'h0005);
        idle(3);
        wr_reg(16'h0205, 16'h0002);
        idle(1);
        check_val("retrig_out", {28'b0, rst_out}, 32'h6);
        rd_reg(16'h0205);
        idle(8);

        // Zero pulse write is a no-op; sticky survives pulse release.
        wr_reg(16'h0205, 16'h0000);
        wr_reg(16'h0204, 16'h0001);
        wr_reg(16'h0206, 16'h0001);
        wr_reg(16'h0205, 16'h0003);
        idle(5);
        check_val("sticky_after_pulse", {28'b0, rst_out}, 32'h1);
        wr_reg(16'h0204, 16'h0000);
        wr_reg(16'h0206, 16'h0003);

        // Reset in the middle of a pulse.
        wr_reg(16'h0205, 16'h000F);
        idle(2);
        do_cycle(1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000);
        check_val("midreset_out", {28'b0, rst_out}, 32'hF);
        check_val("midreset_busy", {31'b0, rst_busy}, 32'h0);
        idle(1);
        rd_reg(16'h0205);
        rd_reg(16'h0206);

`ifdef OSD_SCM_WATCHDOG_EN
        wr_reg(16'h0209, 16'd10);
        idle(12);
        rd_reg(16'h020B);
        check_val("wdt_fired", {31'b0, m_wstat}, 32'h1);
        wr_reg(16'h020B, 16'h0001);
        idle(10);
        for (int k = 0; k < 8; k++) begin
            wr_reg(16'h020A, 16'h0000);
            idle(4);
            check_val("wdt_kicked_busy", {31'b0, rst_busy}, 32'h0);
        end
        wr_reg(16'h0209, 16'h0000);
        idle(8);
`endif

        // Random register traffic.
        for (int n = 0; n < 1500; n++) begin
            op = int'($urandom_range(0, 99));
            if (op < 1) begin
                do_cycle(1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000);
            end else if (op < 25) begin
                idle(1);
            end else if (op < 45) begin
                rd_reg(16'h01FF + 16'($urandom_range(0, 14)));
            end else if (op < 55) begin
                wr_reg(16'h0204, 16'($urandom_range(0, 255)));
            end else if (op < 70) begin
                wr_reg(16'h0205, 16'($urandom_range(0, 255)));
            end else if (op < 78) begin
                wr_reg(16'h0206, 16'($urandom_range(0, 6)));
            end else if (op < 92) begin
                a = 16'h0200 + 16'($urandom_range(0, 12));
                wr_reg(a, 16'($urandom_range(0, 40)));
            end else begin
                do_cycle(1'b1, 1'b1, $urandom_range(0, 1) == 1, 16'h0200 + 16'($urandom_range(0, 8)),
                         2'($urandom_range(1, 3)), 16'($urandom_range(1, 15)));
            end
        end
        idle(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
